// File: rtl/axi_mm_ram_sink_if.sv
// Request/response bundle between an axi_mm source (master) and sink (slave).
// The source drives the request fields; the sink returns read data and the stall.
interface axi_mm_ram_sink_if #(
   parameter int D_BITS = 64,
   parameter int A_BITS = 8
);
   logic [A_BITS-1:0] addr;
   logic [D_BITS-1:0] wr_dat;
   logic              wr;
   logic              rd;
   logic [D_BITS-1:0] rd_dat;
   logic              rd_dat_val;
   logic              wait_rq;

   modport master (
      output addr, wr_dat, wr, rd,
      input  rd_dat, rd_dat_val, wait_rq
   );

   modport slave (
      input  addr, wr_dat, wr, rd,
      output rd_dat, rd_dat_val, wait_rq
   );
endinterface

// File: rtl/axi_mm_ram_sink.sv
// Memory-mapped sink: register-array RAM with programmable wait states and a
// fixed-latency read pipeline. Dual wr/rd requests write only; bad addresses flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no request being held; a new request stalls if WAIT_CYC>0
//   S_WAIT | counting down wait states for the held request
module axi_mm_ram_sink #(
   parameter int D_BITS   = 64,
   parameter int A_BITS   = 8,
   parameter int DEPTH    = 256,
   parameter int RD_LAT   = 2,
   parameter int WAIT_CYC = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   axi_mm_ram_sink_if.slave   bus,
   output logic               o_addr_err,
   output logic               o_proto_err
);
   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_WAIT   = 1'b1;
   localparam bit         HAS_WAIT = (WAIT_CYC != 0);

   logic [0:0]        state;
   logic [3:0]        cnt;
   logic              req;
   logic              wait_rq;
   logic              accept;
   logic              in_range;
   logic              wr_acc;
   logic              rd_acc;
   logic [D_BITS-1:0] rd_word;
   logic [RD_LAT-1:0] vld_pipe;
   logic [D_BITS-1:0] dat_pipe [RD_LAT];
   logic [D_BITS-1:0] mem [DEPTH];

   assign req      = bus.wr | bus.rd;
   assign wait_rq  = (state == S_IDLE && req && HAS_WAIT) ||
                     (state == S_WAIT && cnt != 4'd0);
   assign accept   = req && !wait_rq;
   assign in_range = (32'(bus.addr) < DEPTH);
   assign wr_acc   = accept && bus.wr && in_range && !i_rst;
   assign rd_acc   = accept && bus.rd && !bus.wr;
   assign rd_word  = in_range ? mem[bus.addr] : '0;

   assign bus.wait_rq    = wait_rq;
   assign bus.rd_dat     = dat_pipe[RD_LAT-1];
   assign bus.rd_dat_val = vld_pipe[RD_LAT-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req && HAS_WAIT) begin
                  state <= S_WAIT;
                  cnt   <= 4'(WAIT_CYC - 1);
               end
            end
            S_WAIT: begin
               // dropping req abandons the request without any access
               if (!req || cnt == 4'd0) state <= S_IDLE;
               else                     cnt   <= cnt - 4'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_addr_err  <= 1'b0;
         o_proto_err <= 1'b0;
      end else begin
         if (accept && !in_range)         o_addr_err  <= 1'b1;
         if (accept && bus.wr && bus.rd)  o_proto_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc) mem[bus.addr] <= bus.wr_dat;
   end

   // The last data stage only loads on a valid entry so o_rd_dat holds between pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) dat_pipe[i] <= '0;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            if (i < RD_LAT - 1 || vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
         end
         vld_pipe[0] <= rd_acc;
         if (RD_LAT > 1 || rd_acc) dat_pipe[0] <= rd_word;
      end
   end
endmodule

// File: tb/tb_axi_mm_ram_sink.sv
// Scoreboard bench for axi_mm_ram_sink: two instances (no-wait/short-latency and
// wait-state/long-latency), randomized and directed traffic against a RAM model.
module tb_axi_mm_ram_sink;
   localparam int D_BITS  = 64;
   localparam int A_BITS  = 8;
   localparam int DEPTH0  = 200;
   localparam int RD_LAT0 = 2;
   localparam int WAIT0   = 0;
   localparam int DEPTH1  = 256;
   localparam int RD_LAT1 = 4;
   localparam int WAIT1   = 3;

   typedef struct {
      logic [63:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   logic        addr_err0, proto_err0, addr_err1, proto_err1;
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        e0, e1;
   logic [63:0] last0, last1;
   logic [63:0] mem_m [2][256];
   bit          aerr_m [2];
   bit          perr_m [2];
   int          depth_m [2] = '{DEPTH0, DEPTH1};
   int          lat_m [2]   = '{RD_LAT0, RD_LAT1};
   int          wait_m [2]  = '{WAIT0, WAIT1};

   axi_mm_ram_sink_if #(.D_BITS(D_BITS), .A_BITS(A_BITS)) bus0 ();
   axi_mm_ram_sink_if #(.D_BITS(D_BITS), .A_BITS(A_BITS)) bus1 ();

   axi_mm_ram_sink #(.D_BITS(D_BITS), .A_BITS(A_BITS), .DEPTH(DEPTH0),
                     .RD_LAT(RD_LAT0), .WAIT_CYC(WAIT0)) dut0 (
      .i_clk(clk), .i_rst(rst), .bus(bus0),
      .o_addr_err(addr_err0), .o_proto_err(proto_err0)
   );

   axi_mm_ram_sink #(.D_BITS(D_BITS), .A_BITS(A_BITS), .DEPTH(DEPTH1),
                     .RD_LAT(RD_LAT1), .WAIT_CYC(WAIT1)) dut1 (
      .i_clk(clk), .i_rst(rst), .bus(bus1),
      .o_addr_err(addr_err1), .o_proto_err(proto_err1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: actual run still going required finished by 300000");
      $fatal(1, "watchdog timeout");
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(int lane, bit wr, bit rd, logic [7:0] a, logic [63:0] d);
      if (lane == 0) begin
         bus0.wr = wr; bus0.rd = rd; bus0.addr = a; bus0.wr_dat = d;
      end else begin
         bus1.wr = wr; bus1.rd = rd; bus1.addr = a; bus1.wr_dat = d;
      end
   endtask

   function automatic logic wait_of(int lane);
      return (lane == 0) ? bus0.wait_rq : bus1.wait_rq;
   endfunction

   // Present one request, hold it through the stall, update the model at acceptance.
   task automatic access(int lane, bit wr, bit rd, logic [7:0] a, logic [63:0] d);
      int   stalls;
      bit   ok;
      exp_t e;
      stalls = 0;
      @(negedge clk);
      drive(lane, wr, rd, a, d);
      #1;
      while (wait_of(lane) !== 1'b0 && stalls < 40) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      check($sformatf("stall_cycles_l%0d", lane), 64'(stalls), 64'(wait_m[lane]));
      if (stalls >= 40) begin
         drive(lane, 1'b0, 1'b0, 8'h00, 64'h0);
         return;
      end
      ok = int'(a) < depth_m[lane];
      if (!ok) aerr_m[lane] = 1'b1;
      if (wr && rd) perr_m[lane] = 1'b1;
      if (wr) begin
         if (ok) mem_m[lane][a] = d;
      end else if (rd) begin
         e.d = ok ? mem_m[lane][a] : 64'h0;
         e.c = cyc + lat_m[lane];
         if (lane == 0) q0.push_back(e);
         else           q1.push_back(e);
      end
      @(posedge clk);
      #1;
      drive(lane, 1'b0, 1'b0, 8'h00, 64'h0);
      if (lane == 0) begin
         check("addr_err_l0", 64'(addr_err0), 64'(aerr_m[0]));
         check("proto_err_l0", 64'(proto_err0), 64'(perr_m[0]));
      end else begin
         check("addr_err_l1", 64'(addr_err1), 64'(aerr_m[1]));
         check("proto_err_l1", 64'(proto_err1), 64'(perr_m[1]));
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_dat_l0", bus0.rd_dat, 64'h0);
      check("rst_val_l0", 64'(bus0.rd_dat_val), 64'h0);
      check("rst_wait_l0", 64'(bus0.wait_rq), 64'h0);
      check("rst_aerr_l0", 64'(addr_err0), 64'h0);
      check("rst_perr_l0", 64'(proto_err0), 64'h0);
      check("rst_rd_dat_l1", bus1.rd_dat, 64'h0);
      check("rst_val_l1", 64'(bus1.rd_dat_val), 64'h0);
      check("rst_wait_l1", 64'(bus1.wait_rq), 64'h0);
      check("rst_aerr_l1", 64'(addr_err1), 64'h0);
      check("rst_perr_l1", 64'(proto_err1), 64'h0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus0.rd_dat_val === 1'b1) begin
            if (q0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL rsp_unexpected_l0: actual pulse data %0h required no pulse (cycle %0d)", bus0.rd_dat, cyc);
            end else begin
               e0 = q0.pop_front();
               check("rsp_data_l0", bus0.rd_dat, e0.d);
               check("rsp_cycle_l0", 64'(cyc), 64'(e0.c));
               last0 = e0.d;
            end
         end else begin
            check("val_idle_l0", 64'(bus0.rd_dat_val), 64'h0);
            check("hold_l0", bus0.rd_dat, last0);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus1.rd_dat_val === 1'b1) begin
            if (q1.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL rsp_unexpected_l1: actual pulse data %0h required no pulse (cycle %0d)", bus1.rd_dat, cyc);
            end else begin
               e1 = q1.pop_front();
               check("rsp_data_l1", bus1.rd_dat, e1.d);
               check("rsp_cycle_l1", 64'(cyc), 64'(e1.c));
               last1 = e1.d;
            end
         end else begin
            check("val_idle_l1", 64'(bus1.rd_dat_val), 64'h0);
            check("hold_l1", bus1.rd_dat, last1);
         end
      end
   end

   initial begin
      int          lane;
      int          op;
      logic [7:0]  a;
      logic [63:0] d;

      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 8'h00, 64'h0);
      drive(1, 1'b0, 1'b0, 8'h00, 64'h0);
      aerr_m = '{default: 1'b0};
      perr_m = '{default: 1'b0};
      last0 = 64'h0;
      last1 = 64'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs();
      mon_en = 1'b1;

      for (int i = 0; i < DEPTH0; i++) access(0, 1'b1, 1'b0, 8'(i), {$urandom, $urandom});
      for (int i = 0; i < DEPTH1; i++) access(1, 1'b1, 1'b0, 8'(i), {$urandom, $urandom});

      // write then back-to-back read of the same word
      access(0, 1'b1, 1'b0, 8'h10, 64'hDEAD_BEEF);
      access(0, 1'b0, 1'b1, 8'h10, 64'h0);

      // held read through three wait states
      access(1, 1'b0, 1'b1, 8'h05, 64'h0);

      for (int i = 1; i <= 4; i++) access(0, 1'b1, 1'b0, 8'(i), 64'(i * 'h11));
      for (int i = 1; i <= 4; i++) access(0, 1'b0, 1'b1, 8'(i), 64'h0);

      // out of range on the 200-word instance
      access(0, 1'b1, 1'b0, 8'hF0, 64'hAA);
      access(0, 1'b0, 1'b1, 8'hF0, 64'h0);

      // simultaneous write and read
      access(0, 1'b1, 1'b1, 8'h20, 64'h55);
      access(0, 1'b0, 1'b1, 8'h20, 64'h0);
      access(1, 1'b1, 1'b1, 8'h21, 64'h1234_5678_9ABC_DEF0);
      access(1, 1'b0, 1'b1, 8'h21, 64'h0);

      // abandoned request: no access, next request stalls afresh
      @(negedge clk);
      drive(1, 1'b0, 1'b1, 8'h07, 64'h0);
      #1;
      check("abandon_stall_l1", 64'(bus1.wait_rq), 64'h1);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 8'h00, 64'h0);
      access(1, 1'b0, 1'b1, 8'h08, 64'h0);

      for (int i = 0; i < 120; i++) begin
         lane = int'($urandom_range(0, 1));
         op   = int'($urandom_range(0, 9));
         a    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         d    = {$urandom, $urandom};
         if (op < 4)      access(lane, 1'b1, 1'b0, a, d);
         else if (op < 9) access(lane, 1'b0, 1'b1, a, d);
         else             access(lane, 1'b1, 1'b1, a, d);
      end

      // reset with reads in flight on the long-latency instance
      access(1, 1'b0, 1'b1, 8'h30, 64'h0);
      access(1, 1'b0, 1'b1, 8'h31, 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      q0.delete();
      q1.delete();
      aerr_m = '{default: 1'b0};
      perr_m = '{default: 1'b0};
      last0 = 64'h0;
      last1 = 64'h0;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs();
      repeat (8) @(negedge clk);
      access(1, 1'b0, 1'b1, 8'h05, 64'h0);
      access(0, 1'b0, 1'b1, 8'h10, 64'h0);

      repeat (10) @(negedge clk);
      check("drain_l0", 64'(q0.size()), 64'h0);
      check("drain_l1", 64'(q1.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_mm_ram_sink.md
Name: axi_mm_ram_sink

Overview:
- Responder (sink) end of the if_axi_mm protocol.
- Services write and read requests from an if_axi_mm source against an internal register-array memory.
- Has programmable wait-state insertion and a fixed pipelined read latency.
- Used as the default memory-mapped target behind bridges and in benches that drive put_data/get_data.

Parameters:
- D_BITS, 64, data width of i_wr_dat and o_rd_dat.
- A_BITS, 8, address width.
- DEPTH, 256, number of memory words; must be 1 to 2**A_BITS.
- RD_LAT, 2, cycles from read acceptance to o_rd_dat_val; must be at least 1.
- WAIT_CYC, 0, wait_rq cycles inserted before each request is accepted; range 0 to 15.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_addr  in  A_BITS  request address.
- i_wr_dat  in  D_BITS  write data.
- i_wr  in  1  write request.
- i_rd  in  1  read request.
- o_rd_dat  out  D_BITS  read data.
- o_rd_dat_val  out  1  read data valid, one-cycle pulse per accepted read.
- o_wait_rq  out  1  stall; the source holds its request while this is high.
- o_addr_err  out  1  sticky: an access was made with i_addr >= DEPTH.
- o_proto_err  out  1  sticky: i_wr and i_rd were high in the same cycle.

Behaviour:
- Interface: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- Ports map one-to-one onto the if_axi_mm sink modport (addr, wr_dat, wr, rd, rd_dat, rd_dat_val, wait_rq).
- req = i_wr | i_rd. A request is accepted in a cycle where req=1 and o_wait_rq=0.
- Reset values: o_rd_dat=0, o_rd_dat_val=0, o_addr_err=0, o_proto_err=0, FSM=IDLE, wait counter=0, read pipeline valid bits all 0. Memory contents are not cleared.
- Reset mid-operation: every in-flight read is discarded and no o_rd_dat_val is produced after reset.
- FSM states:
  - IDLE: if req and WAIT_CYC>0, go to WAIT and load cnt=WAIT_CYC-1.
  - WAIT: o_wait_rq=1 while cnt!=0, decrement each cycle. When cnt reaches 0, o_wait_rq=0 and the held request is accepted that cycle; return to IDLE.
  - If req drops while in WAIT, return to IDLE with no access (abandoned request).
- o_wait_rq is combinational: (IDLE & req & WAIT_CYC>0) | (WAIT & cnt!=0). With WAIT_CYC=0, o_wait_rq is constant 0 and every request is accepted the cycle it is presented.
- With WAIT_CYC=N, a held request sees exactly N cycles of o_wait_rq=1, then is accepted.
- After acceptance the FSM sits in IDLE for one cycle. If req is still high there, it is a new request and incurs a fresh WAIT_CYC stall.
- Accepted write: mem[i_addr] <= i_wr_dat at the accepting clock edge.
- Accepted read: mem[i_addr] is sampled at the accepting edge and enters an RD_LAT-deep pipeline. o_rd_dat_val=1 with o_rd_dat exactly RD_LAT cycles after the accepting cycle, in order.
- Reads can be accepted back-to-back every cycle (WAIT_CYC=0); up to RD_LAT reads are in flight.
- o_rd_dat holds its last value when o_rd_dat_val=0.
- Read-after-write to the same address, write accepted in an earlier cycle: the read returns the new data.
- i_wr and i_rd both high:
  - The write is performed and the read is dropped (no o_rd_dat_val).
  - o_proto_err is set, sticky until reset.
  - Stalling and acceptance apply exactly as for a single request.
- Out-of-range address (i_addr >= DEPTH):
  - A write is dropped.
  - A read still returns o_rd_dat_val with o_rd_dat=0.
  - o_addr_err is set, sticky until reset.

Test Plan:
- WAIT_CYC=0, RD_LAT=2: write 0xDEADBEEF to addr 0x10 at t0, read 0x10 at t1 -> o_wait_rq never high; o_rd_dat_val at t3 with 0xDEADBEEF.
- WAIT_CYC=3: hold i_rd to addr 0x05 -> o_wait_rq high for exactly 3 cycles, accepted on the 4th, o_rd_dat_val RD_LAT cycles later.
- Back-to-back reads of addrs 1,2,3,4 (preloaded 0x11..0x44), WAIT_CYC=0 -> four consecutive o_rd_dat_val pulses with 0x11,0x22,0x33,0x44, starting RD_LAT after the first.
- DEPTH=200: write 0xAA to addr 0xF0, then read 0xF0 -> write dropped; read returns 0; o_addr_err=1 and stays 1.
- i_wr=i_rd=1 at addr 0x20 with data 0x55 -> mem[0x20]=0x55 (confirmed by a later read); no read response for the dual cycle; o_proto_err=1.
- Issue 2 reads with RD_LAT=4, assert i_rst 2 cycles later -> no o_rd_dat_val after reset; all outputs 0; the next read works normally.
